mont_modexp: RTL and testbench

Montgomery modular-exponentiation sequencer that computes base^exponent mod n by driving one `montmult` instance through left-to-right square-and-multiply. It sits directly upstream of `montmult`: it converts operands into the Montgomery domain, issues every MonPro, consumes each product, and converts the final value back to the normal domain. It is the core of the Paillier encrypt/decrypt datapath.

---
 rtl/mont_modexp_pkg.sv | 29 ++
 rtl/mont_modexp_if.sv | 26 ++
 rtl/mont_modexp_montmult.sv | 111 +++++++++++
 rtl/mont_modexp.sv | 177 +++++++++++++++++
 tb/tb_mont_modexp.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mont_modexp_pkg.sv
// Shared state encodings and sizing helpers for the Montgomery modexp sequencer
// and its radix-2 shift-add Montgomery multiplier.
package modexp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TO_MONT,
    SQUARE,
    MULT,
    NEXT,
    FROM_MONT,
    DONE
  } modexp_state_t;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_MUL,
    MM_RED_M,
    MM_RED_U
  } mm_phase_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int unsigned EXP_WIDTH_DEF = 1024;
  localparam int unsigned IDX_W         = clog2_min1(EXP_WIDTH_DEF);

endpackage

// File: rtl/mont_modexp_if.sv
// Request/result bundle of the modexp sequencer: operands in, busy/done/result out.
interface mont_modexp_if #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 1024
);
  logic                 start;
  logic [WIDTH-1:0]     base;
  logic [EXP_WIDTH-1:0] exponent;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     n_prime;
  logic [WIDTH-1:0]     r_mod_n;
  logic [WIDTH-1:0]     r2_mod_n;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;

  modport master (
    output start, base, exponent, n, n_prime, r_mod_n, r2_mod_n,
    input  busy, done, result
  );

  modport slave (
    input  start, base, exponent, n, n_prime, r_mod_n, r2_mod_n,
    output busy, done, result
  );
endinterface

// File: rtl/mont_modexp_montmult.sv
// montmult: MonPro(a,b) = a*b*R^-1 mod n via REDC, built from one shared
// shift-add engine run three times (T=a*b, m=T*n' mod R, U=T+m*n). Lm = 3*WIDTH+1.
module montmult
  import modexp_pkg::*;
#(
  parameter int unsigned WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] n_prime,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned      CNT_W    = clog2_min1(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mm_phase_t          phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] t_q, t_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2*WIDTH:0]   sum;
  logic [WIDTH:0]     u;

  // n and n_prime are read live; the sequencer holds them for the whole run.
  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    t_d      = t_q;
    done_d   = 1'b0;
    result_d = result_q;
    sum      = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    u        = sum[2*WIDTH:WIDTH];

    if (phase_q == MM_IDLE) begin
      if (start) begin
        phase_d  = MM_MUL;
        cnt_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
      end
    end else begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        case (phase_q)
          MM_MUL: begin
            t_d      = sum[2*WIDTH-1:0];
            mcand_d  = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
            mplier_d = n_prime;
            acc_d    = '0;
            phase_d  = MM_RED_M;
          end
          MM_RED_M: begin
            mcand_d  = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
            mplier_d = n;
            acc_d    = {1'b0, t_q};
            phase_d  = MM_RED_U;
          end
          default: begin
            // U < 2n, so a single conditional subtraction lands below n.
            result_d = (u >= {1'b0, n}) ? WIDTH'(u - {1'b0, n}) : u[WIDTH-1:0];
            done_d   = 1'b1;
            phase_d  = MM_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= MM_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      t_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      t_q      <= t_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: rtl/mont_modexp.sv
// mont_modexp: left-to-right square-and-multiply over one montmult instance.
// Build option MODEXP_SKIP_LZ_EN skips leading zero exponent bits (not constant-time).
module mont_modexp
  import modexp_pkg::*;
#(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  mont_modexp_if.slave  bus
);

  localparam int unsigned   IW      = clog2_min1(EXP_WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(EXP_WIDTH - 1);

  modexp_state_t        state_q, state_d;
  logic                 wait_q, wait_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     np_q, np_d;
  logic [WIDTH-1:0]     r2_q, r2_d;
  logic [WIDTH-1:0]     xbar_q, xbar_d;
  logic [WIDTH-1:0]     abar_q, abar_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [IW-1:0]        idx_q, idx_d;

  logic                 mm_issue, mm_fire;
  logic                 mm_start, mm_done;
  logic [WIDTH-1:0]     mm_a, mm_b, mm_result;

`ifdef MODEXP_SKIP_LZ_EN
  logic [IW-1:0] msb_idx;
  logic          exp_nz;

  always_comb begin
    msb_idx = '0;
    exp_nz  = |exp_q;
    for (int unsigned i = 0; i < EXP_WIDTH; i++) begin
      if (exp_q[i]) msb_idx = IW'(i);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    base_d   = base_q;
    exp_d    = exp_q;
    n_d      = n_q;
    np_d     = np_q;
    r2_d     = r2_q;
    xbar_d   = xbar_q;
    abar_d   = abar_q;
    result_d = result_q;
    idx_d    = idx_q;
    mm_a     = '0;
    mm_b     = '0;

    // Each MonPro state issues once, then waits for the product pulse.
    mm_issue = (state_q == TO_MONT) || (state_q == SQUARE) ||
               (state_q == MULT)    || (state_q == FROM_MONT);
    mm_start = mm_issue && !wait_q;
    mm_fire  = mm_issue && wait_q && mm_done;
    if (mm_start)     wait_d = 1'b1;
    else if (mm_fire) wait_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.base;
          exp_d   = bus.exponent;
          n_d     = bus.n;
          np_d    = bus.n_prime;
          r2_d    = bus.r2_mod_n;
          abar_d  = bus.r_mod_n;
          wait_d  = 1'b0;
          state_d = TO_MONT;
        end
      end
      TO_MONT: begin
        mm_a = base_q;
        mm_b = r2_q;
        if (mm_fire) begin
          xbar_d = mm_result;
`ifdef MODEXP_SKIP_LZ_EN
          idx_d   = msb_idx;
          state_d = exp_nz ? SQUARE : FROM_MONT;
`else
          idx_d   = IDX_TOP;
          state_d = SQUARE;
`endif
        end
      end
      SQUARE: begin
        mm_a = abar_q;
        mm_b = abar_q;
        if (mm_fire) begin
          abar_d  = mm_result;
          state_d = exp_q[idx_q] ? MULT : NEXT;
        end
      end
      MULT: begin
        mm_a = abar_q;
        mm_b = xbar_q;
        if (mm_fire) begin
          abar_d  = mm_result;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == '0) begin
          state_d = FROM_MONT;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = SQUARE;
        end
      end
      FROM_MONT: begin
        mm_a = abar_q;
        mm_b = WIDTH'(1);
        if (mm_fire) begin
          result_d = mm_result;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_q   <= 1'b0;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      np_q     <= '0;
      r2_q     <= '0;
      xbar_q   <= '0;
      abar_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      np_q     <= np_d;
      r2_q     <= r2_d;
      xbar_q   <= xbar_d;
      abar_q   <= abar_d;
      result_q <= result_d;
      idx_q    <= idx_d;
    end
  end

  montmult #(.WIDTH(WIDTH)) u_montmult (
    .clk     (clk),
    .rst     (rst),
    .start   (mm_start),
    .a       (mm_a),
    .b       (mm_b),
    .n       (n_q),
    .n_prime (np_q),
    .done    (mm_done),
    .result  (mm_result)
  );

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mont_modexp.sv
// Self-checking bench for mont_modexp (WIDTH=8, EXP_WIDTH=8): vector table run
// back to back through a result scoreboard, plus ignore-start, latency and abort sequences.
module tb_mont_modexp;

  localparam int unsigned W  = 8;
  localparam int unsigned EW = 8;
  localparam int unsigned LM = 3 * W + 1;
  localparam int unsigned BUDGET = 5000;

  typedef struct {
    logic [W-1:0]  base;
    logic [EW-1:0] e;
    logic [W-1:0]  n;
    logic [W-1:0]  np;
    logic [W-1:0]  r1;
    logic [W-1:0]  r2;
    logic [W-1:0]  want;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mont_modexp_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

  mont_modexp #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned  compared   = 0;
  int unsigned  mismatched = 0;
  int unsigned  cyc        = 0;
  int unsigned  done_seen  = 0;
  int unsigned  done_cyc   = 0;
  int unsigned  issues     = 0;
  bit           post_chk   = 1'b0;
  logic [W-1:0] sb_q[$];
  vec_t         vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [W-1:0] modpow(input logic [W-1:0] b, input logic [EW-1:0] e,
                                           input logic [W-1:0] m);
    longint unsigned mm, r, x;
    mm = 64'(m);
    r  = 1 % mm;
    x  = 64'(b) % mm;
    for (int i = EW - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * x) % mm;
    end
    return W'(r);
  endfunction

  function automatic int unsigned sq_count(input logic [EW-1:0] e);
`ifdef MODEXP_SKIP_LZ_EN
    int unsigned s = 0;
    for (int i = 0; i < EW; i++) if (e[i]) s = i + 1;
    return s;
`else
    return EW;
`endif
  endfunction

  function automatic int unsigned exp_monpros(input logic [EW-1:0] e);
    return 2 + sq_count(e) + $countones(e);
  endfunction

  function automatic int unsigned exp_lat(input logic [EW-1:0] e);
    return exp_monpros(e) * (LM + 1) + sq_count(e) + 2;
  endfunction

  function automatic vec_t mk13(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] want);
    vec_t v;
    v.base = b; v.e = e; v.n = 8'd13; v.np = 8'd59; v.r1 = 8'd9; v.r2 = 8'd3; v.want = want;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut.mm_start) issues++;
    if (post_chk) begin
      check("done_width", bus.done, 0);
      check("busy_after_done", bus.busy, 0);
      post_chk = 1'b0;
    end
    if (bus.done) begin
      done_seen++;
      done_cyc = cyc;
      post_chk = 1'b1;
      if (sb_q.size() == 0) check("unexpected_done", bus.done, 0);
      else check("result", bus.result, sb_q.pop_front());
    end
  end

  task automatic drive(input vec_t v);
    bus.base     = v.base;
    bus.exponent = v.e;
    bus.n        = v.n;
    bus.n_prime  = v.np;
    bus.r_mod_n  = v.r1;
    bus.r2_mod_n = v.r2;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the done cycle.
  task automatic run(input vec_t v, input bit intrude, output int unsigned lat);
    int unsigned t0, seen0, k;
    drive(v);
    bus.start = 1'b1;
    t0        = cyc;
    seen0     = done_seen;
    issues    = 0;
    sb_q.push_back(v.want);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_running", bus.busy, 1);
    k = 0;
    while (done_seen == seen0 && k < BUDGET) begin
      @(posedge clk); #1;
      k++;
      if (intrude && k == 40) begin
        drive(mk13(8'd5, 8'd3, 8'd0));
        bus.start = 1'b1;
      end else if (intrude && k == 41) begin
        bus.start = 1'b0;
      end
    end
    check("done_seen", done_seen - seen0, 1);
    lat = done_cyc - t0 + 1;
    check("latency", lat, exp_lat(v.e));
    check("monpro_count", issues, exp_monpros(v.e));
  endtask

  task automatic run_abort(input vec_t v);
    int unsigned seen0;
    drive(v);
    bus.start = 1'b1;
    seen0     = done_seen;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (exp_lat(v.e) / 2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (exp_lat(v.e)) @(posedge clk);
    #1;
    check("abort_no_done", done_seen - seen0, 0);
  endtask

  initial begin
    int unsigned lat, lat_lo, lat_hi;
    vec_t v;

    vecs[0] = mk13(8'd2,   8'd10,  8'd10);
    vecs[1] = mk13(8'd7,   8'd0,   8'd1);
    vecs[2] = mk13(8'd3,   8'd255, 8'd1);
    vecs[3] = mk13(8'd200, 8'd1,   8'd5);
    vecs[4] = mk13(8'd0,   8'd5,   8'd0);
    vecs[5] = '{base: 8'd5, e: 8'd0, n: 8'd1, np: 8'd255, r1: 8'd0, r2: 8'd0, want: 8'd0};
    vecs[6] = '{base: 8'd200, e: 8'hFF, n: 8'd251, np: 8'd205, r1: 8'd5, r2: 8'd25,
                want: modpow(8'd200, 8'hFF, 8'd251)};
    vecs[7] = mk13(8'd12,  8'h80,  8'd1);

    rst       = 1'b1;
    bus.start = 1'b0;
    drive(mk13(8'd0, 8'd0, 8'd0));
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);
    check("reset_mm_start", dut.mm_start, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Each run starts in the cycle right after the previous done.
    foreach (vecs[i]) run(vecs[i], 1'b0, lat);

    run(vecs[0], 1'b1, lat);

    v = mk13(8'd2, 8'h01, 8'd2);
    run(v, 1'b0, lat_lo);
    v = mk13(8'd2, 8'h80, 8'd9);
    run(v, 1'b0, lat_hi);
`ifdef MODEXP_SKIP_LZ_EN
    check("lat_skip_gap", lat_hi - lat_lo, 7 * (LM + 2));
`else
    check("lat_equal", lat_hi, lat_lo);
`endif

    run_abort(vecs[0]);
    @(posedge clk); #1;
    run(vecs[4], 1'b0, lat);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
